ula_8_bits_controller: RTL and testbench

- Sequential front-end that sits directly upstream of ula_8_bits_structure.
- Accepts operation requests over a valid/ready handshake and keeps an 8-bit accumulator and a carry flag.
- Drives the ALU inputs (CIN, A, B, X) from registers, holds them for a programmable settle time, then captures S/COUT.
- Returns results over a valid/ready output handshake, which allows multi-byte add chains (ADC).

---
 rtl/ula_8_bits_controller.sv | 139 +++++++++++++
 tb/tb_ula_8_bits_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_8_bits_controller.sv
// Sequential front-end for ula_8_bits_structure: accumulator, carry flag, settle timer, result handshake.
// Optional overflow output OUT_OVF is built when ULA_CTRL_OVERFLOW_EN is defined.
module ula_8_bits_controller #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [2:0] IN_OP,
    input  logic       IN_USE_ACC,
    input  logic [7:0] IN_A,
    input  logic [7:0] IN_B,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic [2:0] ALU_X,
    output logic       ALU_CIN,
    input  logic [7:0] ALU_S,
    input  logic       ALU_COUT,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] OUT_S,
    output logic       OUT_COUT,
    output logic       OUT_ZERO,
`ifdef ULA_CTRL_OVERFLOW_EN
    output logic       OUT_OVF,
`endif
    output logic [7:0] ACC,
    output logic [1:0] dbg_state
);

    // Both handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // the producer holds its data stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       carry;
    logic [2:0] op_q;
    logic       accept;
    logic       arith_op;

    assign accept    = IN_VALID & IN_READY;
    assign arith_op  = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_ADC);
    assign IN_READY  = (state == IDLE);
    assign OUT_VALID = (state == RESP);
    assign dbg_state = state;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (IN_OP == OP_LOAD || IN_OP == OP_CLR) ? RESP : EXEC;
            EXEC: if (cnt == LAST_CNT) state_nxt = RESP;
            RESP: if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ULA_CTRL_OVERFLOW_EN
    logic ovf_calc;
    always_comb begin
        ovf_calc = 1'b0;
        if (op_q == OP_ADD || op_q == OP_ADC)
            ovf_calc = (ALU_A[7] == ALU_B[7]) && (ALU_S[7] != ALU_A[7]);
        else if (op_q == OP_SUB)
            ovf_calc = (ALU_A[7] != ALU_B[7]) && (ALU_S[7] != ALU_A[7]);
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            ACC      <= '0;
            carry    <= 1'b0;
            ALU_A    <= '0;
            ALU_B    <= '0;
            ALU_X    <= '0;
            ALU_CIN  <= 1'b0;
            OUT_S    <= '0;
            OUT_COUT <= 1'b0;
            OUT_ZERO <= 1'b0;
            cnt      <= '0;
            op_q     <= '0;
`ifdef ULA_CTRL_OVERFLOW_EN
            OUT_OVF  <= 1'b0;
`endif
        end else if (accept) begin
            op_q <= IN_OP;
            cnt  <= '0;
            if (IN_OP == OP_LOAD || IN_OP == OP_CLR) begin
                // No ALU round trip: the result is known at the handshake.
                OUT_S    <= (IN_OP == OP_LOAD) ? IN_A : 8'h00;
                ACC      <= (IN_OP == OP_LOAD) ? IN_A : 8'h00;
                OUT_ZERO <= (IN_OP == OP_LOAD) ? (IN_A == 8'h00) : 1'b1;
                OUT_COUT <= 1'b0;
                if (IN_OP == OP_CLR) carry <= 1'b0;
`ifdef ULA_CTRL_OVERFLOW_EN
                OUT_OVF  <= 1'b0;
`endif
            end else begin
                ALU_A   <= IN_USE_ACC ? ACC : IN_A;
                ALU_B   <= IN_B;
                ALU_X   <= (IN_OP == OP_ADC) ? OP_ADD : IN_OP;
                ALU_CIN <= (IN_OP == OP_ADC) ? carry : 1'b0;
            end
        end else if (state == EXEC) begin
            cnt <= cnt + 4'd1;
            if (cnt == LAST_CNT) begin
                OUT_S    <= ALU_S;
                ACC      <= ALU_S;
                OUT_ZERO <= (ALU_S == 8'h00);
                OUT_COUT <= arith_op ? ALU_COUT : 1'b0;
                if (arith_op) carry <= ALU_COUT;
`ifdef ULA_CTRL_OVERFLOW_EN
                OUT_OVF  <= ovf_calc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ula_8_bits_controller.sv
// Directed bench for ula_8_bits_controller with a behavioural ALU model; second instance uses SETTLE_CYCLES=4.
// Covers OUT_OVF when ULA_CTRL_OVERFLOW_EN is defined.
module tb_ula_8_bits_controller;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_LOAD = 3'b101;
    localparam logic [2:0] OP_ADC  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    int n_vec = 0;
    int n_err = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst4 = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_valid4 = 1'b0;
    logic [2:0] in_op = '0;
    logic       in_use_acc = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_cout, out_zero, alu_cin, alu_cout;
    logic [7:0] alu_a, alu_b, alu_s, out_s, acc;
    logic [2:0] alu_x;
    logic [1:0] dbg_state;

    logic       in_ready4, out_valid4, out_cout4, out_zero4, alu_cin4, alu_cout4;
    logic [7:0] alu_a4, alu_b4, alu_s4, out_s4, acc4;
    logic [2:0] alu_x4;
    logic [1:0] dbg_state4;
`ifdef ULA_CTRL_OVERFLOW_EN
    logic       out_ovf, out_ovf4;
`endif

    always #5 clk = ~clk;

    // Reference model of ula_8_bits_structure; SUB reports a borrow on COUT.
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] x, input logic cin);
        logic [8:0] r;
        case (x)
            3'b000:  r = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            3'b001:  r = {1'b0, a} - {1'b0, b} - {8'b0, cin};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, ~a};
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    assign {alu_cout, alu_s}   = alu_model(alu_a, alu_b, alu_x, alu_cin);
    assign {alu_cout4, alu_s4} = alu_model(alu_a4, alu_b4, alu_x4, alu_cin4);

    ula_8_bits_controller #(.SETTLE_CYCLES(1)) u_dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_OP(in_op),
        .IN_USE_ACC(in_use_acc), .IN_A(in_a), .IN_B(in_b), .ALU_A(alu_a), .ALU_B(alu_b),
        .ALU_X(alu_x), .ALU_CIN(alu_cin), .ALU_S(alu_s), .ALU_COUT(alu_cout),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_S(out_s), .OUT_COUT(out_cout),
        .OUT_ZERO(out_zero),
`ifdef ULA_CTRL_OVERFLOW_EN
        .OUT_OVF(out_ovf),
`endif
        .ACC(acc), .dbg_state(dbg_state)
    );

    ula_8_bits_controller #(.SETTLE_CYCLES(4)) u_dut4 (
        .CLK(clk), .RST(rst4), .IN_VALID(in_valid4), .IN_READY(in_ready4), .IN_OP(in_op),
        .IN_USE_ACC(in_use_acc), .IN_A(in_a), .IN_B(in_b), .ALU_A(alu_a4), .ALU_B(alu_b4),
        .ALU_X(alu_x4), .ALU_CIN(alu_cin4), .ALU_S(alu_s4), .ALU_COUT(alu_cout4),
        .OUT_VALID(out_valid4), .OUT_READY(out_ready), .OUT_S(out_s4), .OUT_COUT(out_cout4),
        .OUT_ZERO(out_zero4),
`ifdef ULA_CTRL_OVERFLOW_EN
        .OUT_OVF(out_ovf4),
`endif
        .ACC(acc4), .dbg_state(dbg_state4)
    );

    // Driver: present one request on u_dut; returns 1ns after the handshake edge with junk on IN_*.
    task automatic send(input logic [2:0] op, input logic use_acc, input logic [7:0] a, input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin $display("FAIL send_ready_timeout: in_ready=%b required 1", in_ready); n_err++; end
        n_vec++;
        in_valid = 1'b1; in_op = op; in_use_acc = use_acc; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 8'hA5; in_b = 8'h5A; in_use_acc = ~use_acc;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release_result();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; rst4 = 1'b0;
        if (in_ready !== 1'b1) begin $display("FAIL rst_in_ready: got %b required 1", in_ready); n_err++; end n_vec++;
        if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid: got %b required 0", out_valid); n_err++; end n_vec++;
        if (acc !== 8'h00) begin $display("FAIL rst_acc: got %h required 00", acc); n_err++; end n_vec++;
        if ({alu_a, alu_b, alu_x, alu_cin} !== 20'h0) begin $display("FAIL rst_alu: got %h required 0", {alu_a, alu_b, alu_x, alu_cin}); n_err++; end n_vec++;
        if ({out_s, out_cout, out_zero} !== 10'h0) begin $display("FAIL rst_out: got %h required 0", {out_s, out_cout, out_zero}); n_err++; end n_vec++;
    endtask

    task automatic test_arith();
        logic [2:0] ops [5];
        logic [7:0] exp_s [5];
        int lat;
        ops   = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT};
        exp_s = '{8'h84, 8'h82, 8'h01, 8'h83, 8'h7C};
        for (int i = 0; i < 5; i++) begin
            send(ops[i], 1'b0, 8'h83, 8'h01);
            if (alu_x !== ops[i]) begin $display("FAIL arith%0d_alu_x: got %b required %b", i, alu_x, ops[i]); n_err++; end n_vec++;
            if (alu_cin !== 1'b0) begin $display("FAIL arith%0d_alu_cin: got %b required 0", i, alu_cin); n_err++; end n_vec++;
            if (out_valid !== 1'b0) begin $display("FAIL arith%0d_early_valid: got %b required 0", i, out_valid); n_err++; end n_vec++;
            wait_valid(lat);
            if (lat != 1) begin $display("FAIL arith%0d_latency: got %0d required 1", i, lat); n_err++; end n_vec++;
            if (out_s !== exp_s[i]) begin $display("FAIL arith%0d_out_s: got %h required %h", i, out_s, exp_s[i]); n_err++; end n_vec++;
            if ({out_cout, out_zero} !== 2'b00) begin $display("FAIL arith%0d_cout_zero: got %b required 00", i, {out_cout, out_zero}); n_err++; end n_vec++;
            if (acc !== exp_s[i]) begin $display("FAIL arith%0d_acc: got %h required %h", i, acc, exp_s[i]); n_err++; end n_vec++;
            release_result();
        end
    endtask

    task automatic test_carry_chain();
        int lat;
        send(OP_ADD, 1'b0, 8'hFF, 8'h01); wait_valid(lat);
        if ({out_s, out_zero, out_cout} !== 10'h003) begin $display("FAIL chain_add_ff: got s=%h z=%b c=%b required s=00 z=1 c=1", out_s, out_zero, out_cout); n_err++; end n_vec++;
        release_result();
        send(OP_ADC, 1'b0, 8'h00, 8'h00);
        if ({alu_x, alu_cin} !== 4'b0001) begin $display("FAIL chain_adc_alu: got x=%b cin=%b required x=000 cin=1", alu_x, alu_cin); n_err++; end n_vec++;
        wait_valid(lat);
        if ({out_s, out_cout, out_zero} !== 10'h004) begin $display("FAIL chain_adc_out: got s=%h c=%b z=%b required s=01 c=0 z=0", out_s, out_cout, out_zero); n_err++; end n_vec++;
        release_result();
        send(OP_ADC, 1'b0, 8'h00, 8'h00);
        if (alu_cin !== 1'b0) begin $display("FAIL chain_adc_cin_cleared: got %b required 0", alu_cin); n_err++; end n_vec++;
        wait_valid(lat);
        if ({out_s, out_zero} !== 9'h001) begin $display("FAIL chain_adc2_out: got s=%h z=%b required s=00 z=1", out_s, out_zero); n_err++; end n_vec++;
        release_result();
        // Logic ops must leave the carry flag alone.
        send(OP_ADD, 1'b0, 8'hFF, 8'h01); wait_valid(lat); release_result();
        send(OP_AND, 1'b0, 8'hFF, 8'h0F); wait_valid(lat);
        if ({out_s, out_cout} !== 9'h01E) begin $display("FAIL chain_and_out: got s=%h c=%b required s=0f c=0", out_s, out_cout); n_err++; end n_vec++;
        release_result();
        send(OP_ADC, 1'b0, 8'h00, 8'h00);
        if (alu_cin !== 1'b1) begin $display("FAIL chain_carry_kept: got %b required 1", alu_cin); n_err++; end n_vec++;
        wait_valid(lat); release_result();
        send(OP_ADD, 1'b0, 8'hFF, 8'h01); wait_valid(lat); release_result();
        send(OP_CLR, 1'b0, 8'h77, 8'h66); wait_valid(lat);
        if (lat != 0) begin $display("FAIL clr_latency: got %0d required 0", lat); n_err++; end n_vec++;
        if ({out_s, out_cout, out_zero, acc} !== 18'h00100) begin $display("FAIL clr_out: got s=%h c=%b z=%b acc=%h required 00/0/1/00", out_s, out_cout, out_zero, acc); n_err++; end n_vec++;
        release_result();
        send(OP_ADC, 1'b0, 8'h00, 8'h05);
        if (alu_cin !== 1'b0) begin $display("FAIL clr_carry: got %b required 0", alu_cin); n_err++; end n_vec++;
        wait_valid(lat);
        if (out_s !== 8'h05) begin $display("FAIL clr_adc_out: got %h required 05", out_s); n_err++; end n_vec++;
        release_result();
    endtask

    task automatic test_backpressure();
        int lat;
        send(OP_LOAD, 1'b0, 8'h10, 8'h99); wait_valid(lat);
        if (lat != 0) begin $display("FAIL load_latency: got %0d required 0", lat); n_err++; end n_vec++;
        if (acc !== 8'h10) begin $display("FAIL load_acc: got %h required 10", acc); n_err++; end n_vec++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if ({out_valid, in_ready, out_s} !== 10'h210) begin $display("FAIL hold%0d: got v=%b r=%b s=%h required v=1 r=0 s=10", i, out_valid, in_ready, out_s); n_err++; end n_vec++;
        end
        release_result();
        if ({out_valid, in_ready} !== 2'b01) begin $display("FAIL release_state: got v=%b r=%b required v=0 r=1", out_valid, in_ready); n_err++; end n_vec++;
        send(OP_ADD, 1'b1, 8'hEE, 8'h05);
        if (alu_a !== 8'h10) begin $display("FAIL acc_operand: got %h required 10", alu_a); n_err++; end n_vec++;
        wait_valid(lat);
        if ({out_s, acc} !== 16'h1515) begin $display("FAIL acc_add: got s=%h acc=%h required 15/15", out_s, acc); n_err++; end n_vec++;
        release_result();
    endtask

    task automatic test_back_to_back();
        int hs;
        hs = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = OP_ADD; in_use_acc = 1'b1; in_a = 8'h00; in_b = 8'h01; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (in_ready === 1'b1) hs++;
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        if (hs != 3) begin $display("FAIL b2b_handshakes: got %0d required 3", hs); n_err++; end n_vec++;
        if (acc !== 8'h18) begin $display("FAIL b2b_acc: got %h required 18", acc); n_err++; end n_vec++;
    endtask

`ifdef ULA_CTRL_OVERFLOW_EN
    task automatic test_overflow();
        int lat;
        send(OP_ADD, 1'b0, 8'h7F, 8'h01); wait_valid(lat);
        if ({out_s, out_ovf} !== 9'h101) begin $display("FAIL ovf_add: got s=%h ovf=%b required 80/1", out_s, out_ovf); n_err++; end n_vec++;
        release_result();
        send(OP_SUB, 1'b0, 8'h80, 8'h01); wait_valid(lat);
        if ({out_s, out_ovf} !== 9'h0FF) begin $display("FAIL ovf_sub: got s=%h ovf=%b required 7f/1", out_s, out_ovf); n_err++; end n_vec++;
        release_result();
        send(OP_ADD, 1'b0, 8'h01, 8'h01); wait_valid(lat);
        if (out_ovf !== 1'b0) begin $display("FAIL ovf_none: got %b required 0", out_ovf); n_err++; end n_vec++;
        release_result();
    endtask
`endif

    task automatic test_reset_midop();
        int lat;
        logic seen;
        @(negedge clk);
        in_valid4 = 1'b1; in_op = OP_ADD; in_use_acc = 1'b0; in_a = 8'h20; in_b = 8'h03;
        @(posedge clk); #1; in_valid4 = 1'b0;
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat != 4) begin $display("FAIL s4_latency: got %0d required 4", lat); n_err++; end n_vec++;
        if ({out_s4, acc4} !== 16'h2323) begin $display("FAIL s4_result: got s=%h acc=%h required 23/23", out_s4, acc4); n_err++; end n_vec++;
        @(negedge clk); out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b1; in_op = OP_ADD; in_a = 8'h01; in_b = 8'h02;
        @(posedge clk); #1; in_valid4 = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(posedge clk); #1; seen |= out_valid4; end
        @(negedge clk); rst4 = 1'b1;
        @(posedge clk); #1; rst4 = 1'b0; seen |= out_valid4;
        if ({in_ready4, acc4, alu_a4} !== 17'h10000) begin $display("FAIL midrst_state: got r=%b acc=%h alu_a=%h required 1/00/00", in_ready4, acc4, alu_a4); n_err++; end n_vec++;
        repeat (6) begin @(posedge clk); #1; seen |= out_valid4; end
        if (seen !== 1'b0) begin $display("FAIL midrst_no_valid: got %b required 0", seen); n_err++; end n_vec++;
    endtask

    initial begin
        test_reset();
        test_arith();
        test_carry_chain();
        test_backpressure();
        test_back_to_back();
`ifdef ULA_CTRL_OVERFLOW_EN
        test_overflow();
`endif
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
